// File: rtl/gray_step_pkg.sv
// Shared types and constants for the gray-code step controller.
package gray_step_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Up-count order of the 3-bit gray phase; entry 0 is the reset phase.
    localparam logic [7:0][2:0] GRAY_SEQ = {
        3'b100, 3'b101, 3'b111, 3'b110,
        3'b010, 3'b011, 3'b001, 3'b000
    };

endpackage

// File: rtl/gray_next.sv
// Combinational next-phase lookup: one gray step forward (dir=1) or back (dir=0).
module gray_next
    import gray_step_pkg::*;
(
    input  logic [2:0] phase,
    input  logic       dir,
    output logic [2:0] next_phase
);

    logic [2:0] idx;

    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (GRAY_SEQ[i] == phase) idx = 3'(i);
        end
        // 3-bit index arithmetic wraps 7<->0 for free.
        next_phase = dir ? GRAY_SEQ[idx + 3'd1] : GRAY_SEQ[idx - 3'd1];
    end

endmodule

// File: rtl/gray_step_ctrl.sv
// Command-driven gray-phase stepper: takes N steps at a programmable interval,
// abortable, with a one-cycle done/aborted completion pulse.
module gray_step_ctrl
    import gray_step_pkg::*;
#(
    parameter int STEP_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [DIV_W-1:0]  cmd_div,
    input  logic              abort,
    output logic [2:0]        phase,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [STEP_W-1:0] steps_left
);

    state_t            state, state_nxt;
    logic [DIV_W-1:0]  timer, div_q;
    logic              dir_q;
    logic              aborted_q;
    logic              accept, step;
    logic [2:0]        phase_nxt;

    gray_next u_gray_next (
        .phase      (phase),
        .dir        (dir_q),
        .next_phase (phase_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = (cmd_steps == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                // Abort wins over a due step on the same edge.
                if (abort) begin
                    state_nxt = DONE;
                end else if (timer == '0) begin
                    step = 1'b1;
                    if (steps_left == STEP_W'(1)) state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign aborted = done & aborted_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase      <= 3'b000;
            steps_left <= '0;
            timer      <= '0;
            div_q      <= '0;
            dir_q      <= 1'b0;
            aborted_q  <= 1'b0;
        end else if (accept) begin
            dir_q      <= cmd_dir;
            div_q      <= cmd_div;
            timer      <= cmd_div;
            steps_left <= cmd_steps;
            aborted_q  <= 1'b0;
        end else if (state == RUN) begin
            if (abort) begin
                aborted_q <= 1'b1;
            end else if (step) begin
                phase      <= phase_nxt;
                steps_left <= steps_left - STEP_W'(1);
                timer      <= div_q;
            end else begin
                timer <= timer - DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_gray_step_ctrl.sv
// Directed-vector bench for gray_step_ctrl; expected values are hand-derived.
module tb_gray_step_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_ready, cmd_dir, abort;
    logic [7:0] cmd_steps, cmd_div, steps_left;
    logic [2:0] phase, prev;
    logic       busy, done, aborted;

    int nvec = 0;
    int nmis = 0;

    gray_step_ctrl #(.STEP_W(8), .DIV_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_steps  (cmd_steps),
        .cmd_div    (cmd_div),
        .abort      (abort),
        .phase      (phase),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .steps_left (steps_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Offer a command for one cycle; returns at the negedge after the accept edge.
    task automatic send(input logic d, input logic [7:0] s, input logic [7:0] v);
        cmd_valid = 1'b1; cmd_dir = d; cmd_steps = s; cmd_div = v;
        edges(1);
        cmd_valid = 1'b0; cmd_steps = 8'hee; cmd_div = 8'hee;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        edges(2);
        reset = 1'b0;
        edges(1);
    endtask

    logic [2:0] exp10 [10] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111,
                               3'b101, 3'b100, 3'b000, 3'b001, 3'b011};

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0;
        cmd_steps = '0; cmd_div = '0; abort = 1'b0;
        edges(2);
        reset = 1'b0;
        edges(1);

        // reset state
        chk("rst_phase", 32'(phase), 32'h0);
        chk("rst_ready", 32'(cmd_ready), 32'h1);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_done",  32'(done), 32'h0);
        chk("rst_abrt",  32'(aborted), 32'h0);
        chk("rst_left",  32'(steps_left), 32'h0);

        // up, 3 steps, div 0
        send(1'b1, 8'd3, 8'd0);
        chk("t1_busy", 32'(busy), 32'h1);
        chk("t1_left", 32'(steps_left), 32'd3);
        chk("t1_rdy",  32'(cmd_ready), 32'h0);
        edges(1); chk("t1_p1", 32'(phase), 32'b001);
        edges(1); chk("t1_p2", 32'(phase), 32'b011);
        edges(1); chk("t1_p3", 32'(phase), 32'b010);
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_abrt", 32'(aborted), 32'h0);
        chk("t1_dbsy", 32'(busy), 32'h0);
        chk("t1_drdy", 32'(cmd_ready), 32'h0);
        edges(1);
        chk("t1_dn0",  32'(done), 32'h0);
        chk("t1_idle", 32'(cmd_ready), 32'h1);

        // down, 2 steps, div 2, from 000
        do_reset();
        send(1'b0, 8'd2, 8'd2);
        edges(2); chk("t2_hold", 32'(phase), 32'b000);
        edges(1); chk("t2_p1",   32'(phase), 32'b100);
        edges(2); chk("t2_hold2", 32'(phase), 32'b100);
        edges(1); chk("t2_p2",   32'(phase), 32'b101);
        chk("t2_done", 32'(done), 32'h1);
        edges(1); chk("t2_dn0", 32'(done), 32'h0);

        // up, 10 steps, div 0: wrap and single-bit change every step
        do_reset();
        send(1'b1, 8'd10, 8'd0);
        prev = phase;
        for (int i = 0; i < 10; i++) begin
            edges(1);
            chk($sformatf("t3_p%0d", i), 32'(phase), 32'(exp10[i]));
            chk($sformatf("t3_ham%0d", i), 32'($countones(phase ^ prev)), 32'd1);
            prev = phase;
        end
        chk("t3_done", 32'(done), 32'h1);

        // abort while a step is due
        edges(1);
        send(1'b1, 8'd5, 8'd3);
        edges(4); chk("t4_p1", 32'(phase), 32'b010);
        chk("t4_l1", 32'(steps_left), 32'd4);
        edges(4); chk("t4_p2", 32'(phase), 32'b110);
        edges(3); chk("t4_busy", 32'(busy), 32'h1);
        abort = 1'b1;
        edges(1); abort = 1'b0;
        chk("t4_done", 32'(done), 32'h1);
        chk("t4_abrt", 32'(aborted), 32'h1);
        chk("t4_left", 32'(steps_left), 32'd3);
        chk("t4_p3",   32'(phase), 32'b110);
        edges(1);
        chk("t4_dn0", 32'(done), 32'h0);
        chk("t4_ab0", 32'(aborted), 32'h0);

        // zero-step command
        send(1'b1, 8'd0, 8'd5);
        chk("t5_done", 32'(done), 32'h1);
        chk("t5_abrt", 32'(aborted), 32'h0);
        chk("t5_ph",   32'(phase), 32'b110);
        edges(1);

        // cmd_valid held through RUN: only re-accepted once back in IDLE
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 8'd2; cmd_div = 8'd0;
        edges(1);
        cmd_steps = 8'd7;
        chk("t6_left", 32'(steps_left), 32'd2);
        edges(1); chk("t6_p1", 32'(phase), 32'b111);
        chk("t6_l1", 32'(steps_left), 32'd1);
        edges(1); chk("t6_p2", 32'(phase), 32'b101);
        chk("t6_done", 32'(done), 32'h1);
        edges(1); chk("t6_rdy", 32'(cmd_ready), 32'h1);
        edges(1); chk("t6_acc", 32'(steps_left), 32'd7);
        cmd_valid = 1'b0; abort = 1'b1;
        edges(1); abort = 1'b0;
        chk("t6_abrt", 32'(aborted), 32'h1);
        chk("t6_nostep", 32'(phase), 32'b101);
        edges(1);

        // abort in IDLE ignored
        abort = 1'b1;
        edges(1); abort = 1'b0;
        chk("t7_done", 32'(done), 32'h0);
        chk("t7_rdy",  32'(cmd_ready), 32'h1);

        // reset mid-RUN
        send(1'b1, 8'd5, 8'd1);
        edges(2); chk("t8_p1", 32'(phase), 32'b100);
        reset = 1'b1;
        #1;
        chk("t8_ph",   32'(phase), 32'b000);
        chk("t8_busy", 32'(busy), 32'h0);
        edges(1); reset = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 6; i++) begin
                edges(1);
                if (done) seen++;
            end
            chk("t8_nodone", 32'(seen), 32'd0);
        end
        send(1'b1, 8'd1, 8'd0);
        chk("t8_busy2", 32'(busy), 32'h1);
        edges(1); chk("t8_p2", 32'(phase), 32'b001);
        chk("t8_done", 32'(done), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/gray_step_ctrl.md
GRAY_STEP_CTRL -- requirements
Module: gray_step_ctrl

Interface
REQ-001 Parameter STEP_W, default 8, width of step-count command and steps_left.
REQ-002 Parameter DIV_W, default 8, width of step-interval divider command.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  controller can accept a command.
REQ-007 cmd_dir  input  1  1 = count up the gray sequence, 0 = count down.
REQ-008 cmd_steps  input  STEP_W  number of gray steps to perform.
REQ-009 cmd_div  input  DIV_W  interval; one step every cmd_div+1 cycles.
REQ-010 abort  input  1  terminate the active command.
REQ-011 phase  output  3  current 3-bit gray phase, drives the motor/encoder datapath.
REQ-012 busy  output  1  command in progress.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 aborted  output  1  qualifies done; 1 when the command ended by abort.
REQ-015 steps_left  output  STEP_W  remaining steps of the active command.

Function
REQ-016 Gray up sequence SHALL be 000,001,011,010,110,111,101,100, then wrap to 000; down SHALL be the exact reverse, 000 wrapping to 100.
REQ-017 FSM SHALL have states IDLE, RUN, DONE.
REQ-018 IDLE: cmd_ready=1, busy=0; handshake fires on cmd_valid&&cmd_ready at a rising edge, capturing dir, steps, div.
REQ-019 Accepted cmd_steps==0 SHALL go IDLE->DONE with no phase change and aborted=0.
REQ-020 Accepted cmd_steps>0 SHALL go IDLE->RUN, timer=cmd_div, steps_left=cmd_steps.
REQ-021 RUN: cmd_ready=0, busy=1; timer SHALL decrement by 1 each cycle while nonzero.
REQ-022 RUN, timer==0: phase SHALL advance one gray step in captured dir, steps_left decrements, timer reloads to captured div, all at the same edge.
REQ-023 First step SHALL occur at edge k+div+1 after acceptance edge k; subsequent steps every div+1 cycles; div=0 gives one step per cycle.
REQ-024 When the step drives steps_left to 0, next state SHALL be DONE.
REQ-025 DONE: done=1, busy=0, cmd_ready=0 for exactly one cycle, then IDLE.
REQ-026 abort=1 in RUN SHALL go to DONE at the next edge with aborted=1, no step that edge even if timer==0; steps_left holds its value.
REQ-027 abort in IDLE or DONE SHALL be ignored.
REQ-028 aborted SHALL be 0 whenever done=0.
REQ-029 phase SHALL hold between commands; a new command continues from the current phase.
REQ-030 Exactly one phase bit SHALL change per step; phase SHALL never change outside RUN.
REQ-031 Command inputs SHALL be ignored outside the handshake; captured values are stable during RUN.

Reset
REQ-032 Reset SHALL force state IDLE, phase=000, steps_left=0, timer=0, done=0, aborted=0, busy=0, cmd_ready=1 (after release).
REQ-033 Reset mid-RUN SHALL discard the command immediately without a done pulse.

Structure
REQ-034 Package gray_step_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the 8-entry gray sequence constant.
REQ-035 Sub-module gray_next SHALL be the combinational next-phase function (inputs phase, dir; output next phase); the controller instantiates it once.
REQ-036 State register, timer and step counter SHALL be flops in gray_step_ctrl on the async reset.

Verification
REQ-037 Reset, then cmd up, steps=3, div=0 -> phase 001,011,010 on edges k+1..k+3; done pulse at k+4; aborted=0.
REQ-038 phase=000, cmd down, steps=2, div=2 -> phase 100 at k+3, 101 at k+6; done one cycle later.
REQ-039 cmd up, steps=10, div=0 from 000 -> wraps through 100 to 000 then 001, 011; final phase 011; 1-bit Hamming distance every step.
REQ-040 cmd steps=5, div=3, abort asserted on the cycle timer==0 after 2 steps -> no third step, done=1 with aborted=1, steps_left=3.
REQ-041 cmd steps=0 -> done pulse one cycle after acceptance, phase unchanged; cmd_valid held high during RUN -> not accepted until IDLE.
REQ-042 reset asserted mid-RUN -> phase=000, busy=0, no done pulse; new command accepted after release.
